// File: rtl/image_reader_pkg.sv
// rtl/image_reader_pkg.sv - shared constants, state encoding and header helpers for the image stream reader
package image_reader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_MAGIC  = 3'd1;
    localparam state_t ST_DIMS   = 3'd2;
    localparam state_t ST_CHECK  = 3'd3;
    localparam state_t ST_STREAM = 3'd4;
    localparam state_t ST_DONE   = 3'd5;
    localparam state_t ST_ERR    = 3'd6;

    localparam logic [31:0] MAGIC_WORD = 32'h4D4D002A;
    localparam logic [7:0]  XDIM_OFS   = 8'h1C;
    localparam logic [7:0]  YDIM_OFS   = 8'h28;
    localparam logic [7:0]  PIX_OFS    = 8'hC0;

    // idx 0 is the byte stored at address 0 (most significant byte of the word)
    function automatic logic [7:0] magic_byte(input logic [1:0] idx);
        return 8'(MAGIC_WORD >> {~idx, 3'b000});
    endfunction

endpackage

// File: rtl/rgb_packer.sv
// rtl/rgb_packer.sv - packs R,G,B bytes into pixels behind a valid/ready output with a one-entry skid buffer
module rgb_packer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       room,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_r,
    output logic [7:0] out_g,
    output logic [7:0] out_b
);

    logic [1:0]  phase;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [23:0] out_px;
    logic [23:0] skid_px;
    logic        skid_valid;
    logic        pix_done;
    logic        out_free;
    logic [23:0] new_px;

    assign pix_done = in_valid && (phase == 2'd2);
    assign new_px   = {b0, b1, in_data};
    assign out_free = !out_valid || out_ready;

    // A read issued while the skid is empty can land at most one byte after the
    // skid fills, and that byte only starts a new pixel, so nothing overflows.
    assign room = !skid_valid;

    assign {out_r, out_g, out_b} = out_px;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            phase      <= 2'd0;
            b0         <= 8'd0;
            b1         <= 8'd0;
            out_px     <= 24'd0;
            skid_px    <= 24'd0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (in_valid) begin
                case (phase)
                    2'd0: begin
                        b0    <= in_data;
                        phase <= 2'd1;
                    end
                    2'd1: begin
                        b1    <= in_data;
                        phase <= 2'd2;
                    end
                    default: phase <= 2'd0;
                endcase
            end

            if (out_free) begin
                if (skid_valid) begin
                    out_px     <= skid_px;
                    out_valid  <= 1'b1;
                    skid_valid <= pix_done;
                    if (pix_done) begin
                        skid_px <= new_px;
                    end
                end else if (pix_done) begin
                    out_px    <= new_px;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (pix_done) begin
                skid_px    <= new_px;
                skid_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/image_stream_reader.sv
// rtl/image_stream_reader.sv - decodes a big-endian RGB image from a synchronous ROM into a pixel stream
module image_stream_reader
    import image_reader_pkg::*;
#(
    parameter int ADDR_W  = 20,
    parameter int MAX_DIM = 1024
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [15:0]       xdim,
    output logic [15:0]       ydim,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic              sof,
    output logic              eol,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [16:0] MAX_DIM_W = 17'(MAX_DIM);

    state_t      state;
    logic [2:0]  cnt;
    logic        rd_pending;
    logic [1:0]  iss_phase;
    logic [15:0] iss_col;
    logic [15:0] iss_row;
    logic        iss_done;
    logic [15:0] col;
    logic [15:0] row;
    logic        room;
    logic        start_ok;
    logic        issue;
    logic        hs;
    logic        last_col;
    logic        last_row;
    logic        dims_bad;

    assign start_ok = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign issue    = (state == ST_STREAM) && room && !iss_done;
    assign hs       = pix_valid && pix_ready;
    assign last_col = (col == xdim - 16'd1);
    assign last_row = (row == ydim - 16'd1);
    assign dims_bad = (xdim == 16'd0) || (ydim == 16'd0) ||
                      ({1'b0, xdim} > MAX_DIM_W) || ({1'b0, ydim} > MAX_DIM_W);

    assign busy  = (state == ST_MAGIC) || (state == ST_DIMS) ||
                   (state == ST_CHECK) || (state == ST_STREAM);
    assign done  = (state == ST_DONE);
    assign error = (state == ST_ERR);
    assign sof   = pix_valid && (col == 16'd0) && (row == 16'd0);
    assign eol   = pix_valid && last_col;

    rgb_packer u_packer (
        .clk       (pclk),
        .rst       (rst),
        .clr       (start_ok),
        .in_valid  (rd_pending),
        .in_data   (rom_data),
        .room      (room),
        .out_valid (pix_valid),
        .out_ready (pix_ready),
        .out_r     (r),
        .out_g     (g),
        .out_b     (b)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rom_addr   <= '0;
            xdim       <= 16'd0;
            ydim       <= 16'd0;
            cnt        <= 3'd0;
            rd_pending <= 1'b0;
            iss_phase  <= 2'd0;
            iss_col    <= 16'd0;
            iss_row    <= 16'd0;
            iss_done   <= 1'b0;
            col        <= 16'd0;
            row        <= 16'd0;
        end else begin
            rd_pending <= issue;
            if (start_ok) begin
                state     <= ST_MAGIC;
                rom_addr  <= '0;
                xdim      <= 16'd0;
                ydim      <= 16'd0;
                cnt       <= 3'd0;
                iss_phase <= 2'd0;
                iss_col   <= 16'd0;
                iss_row   <= 16'd0;
                iss_done  <= 1'b0;
                col       <= 16'd0;
                row       <= 16'd0;
            end else begin
                case (state)
                    // ROM data lags the address by one cycle, so byte cnt-1 is checked at cnt
                    ST_MAGIC: begin
                        cnt <= cnt + 3'd1;
                        if (cnt < 3'd3) begin
                            rom_addr <= rom_addr + 1'b1;
                        end
                        if (cnt != 3'd0 && rom_data != magic_byte(2'(cnt - 3'd1))) begin
                            state <= ST_ERR;
                        end else if (cnt == 3'd4) begin
                            state    <= ST_DIMS;
                            cnt      <= 3'd0;
                            rom_addr <= ADDR_W'(XDIM_OFS);
                        end
                    end
                    ST_DIMS: begin
                        cnt <= cnt + 3'd1;
                        case (cnt)
                            3'd0: rom_addr <= rom_addr + 1'b1;
                            3'd1: begin
                                xdim[15:8] <= rom_data;
                                rom_addr   <= ADDR_W'(YDIM_OFS);
                            end
                            3'd2: begin
                                xdim[7:0] <= rom_data;
                                rom_addr  <= rom_addr + 1'b1;
                            end
                            3'd3: ydim[15:8] <= rom_data;
                            3'd4: begin
                                ydim[7:0] <= rom_data;
                                state     <= ST_CHECK;
                            end
                            default: ;
                        endcase
                    end
                    ST_CHECK: begin
                        if (dims_bad) begin
                            state <= ST_ERR;
                        end else begin
                            state    <= ST_STREAM;
                            rom_addr <= ADDR_W'(PIX_OFS);
                        end
                    end
                    ST_STREAM: begin
                        if (issue) begin
                            rom_addr <= rom_addr + 1'b1;
                            if (iss_phase == 2'd2) begin
                                iss_phase <= 2'd0;
                                if (iss_col == xdim - 16'd1) begin
                                    iss_col <= 16'd0;
                                    if (iss_row == ydim - 16'd1) begin
                                        iss_done <= 1'b1;
                                    end else begin
                                        iss_row <= iss_row + 16'd1;
                                    end
                                end else begin
                                    iss_col <= iss_col + 16'd1;
                                end
                            end else begin
                                iss_phase <= iss_phase + 2'd1;
                            end
                        end
                        if (hs) begin
                            if (last_col) begin
                                col <= 16'd0;
                                if (last_row) begin
                                    state <= ST_DONE;
                                end else begin
                                    row <= row + 16'd1;
                                end
                            end else begin
                                col <= col + 16'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_image_stream_reader.sv
// tb/tb_image_stream_reader.sv - directed self-checking bench for image_stream_reader
module tb_image_stream_reader;

    logic        pclk = 1'b0;
    logic        rst;
    logic        start;
    logic [19:0] rom_addr;
    logic [7:0]  rom_data;
    logic [15:0] xdim;
    logic [15:0] ydim;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        sof;
    logic        eol;
    logic        busy;
    logic        done;
    logic        error;

    always #5 pclk = ~pclk;

    image_stream_reader #(.ADDR_W(20), .MAX_DIM(1024)) dut (
        .pclk      (pclk),
        .rst       (rst),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .xdim      (xdim),
        .ydim      (ydim),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .r         (r),
        .g         (g),
        .b         (b),
        .sof       (sof),
        .eol       (eol),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    logic [7:0] rom [0:4095];
    always @(posedge pclk) rom_data <= rom[rom_addr[11:0]];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // handshake monitor: records accepted pixels and checks hold-while-stalled
    longint      cyc = 0;
    int          valid_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [25:0] prev_pix = '0;
    logic [25:0] pq[$];
    longint      tq[$];

    always @(negedge pclk) begin
        cyc <= cyc + 1;
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) check("hold_stable", {pix_valid, r, g, b, sof, eol}, {1'b1, prev_pix});
            if (pix_valid) valid_cnt <= valid_cnt + 1;
            if (pix_valid && pix_ready) begin
                pq.push_back({r, g, b, sof, eol});
                tq.push_back(cyc);
            end
            prev_stall <= pix_valid && !pix_ready;
            prev_pix   <= {r, g, b, sof, eol};
        end
    end

    function automatic logic [7:0] pat(input int mode, input int i);
        case (mode)
            0:       return 8'((i + 1) * 16);
            1:       return 8'(17 * (i + 1));
            default: return 8'(i * 7 + 3);
        endcase
    endfunction

    task automatic load(input logic [15:0] w, input logic [15:0] h, input logic [7:0] m0,
                        input int mode, input int nbytes);
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rom[0]  = m0;
        rom[1]  = 8'h4D;
        rom[2]  = 8'h00;
        rom[3]  = 8'h2A;
        rom[28] = w[15:8];
        rom[29] = w[7:0];
        rom[40] = h[15:8];
        rom[41] = h[7:0];
        for (int i = 0; i < nbytes; i++) rom[192 + i] = pat(mode, i);
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic pulse_start();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, input string tag);
        for (int i = 0; i < max; i++) begin
            @(negedge pclk);
            if (done) break;
        end
        check(tag, done, 1'b1);
    endtask

    task automatic wait_error(input int max, input string tag);
        for (int i = 0; i < max; i++) begin
            @(negedge pclk);
            if (error) break;
        end
        check(tag, error, 1'b1);
    endtask

    task automatic check_2x2(input int base, input string tag);
        check({tag, "_count"}, pq.size(), base + 4);
        check({tag, "_px0"}, pq[base],     {24'h102030, 1'b1, 1'b0});
        check({tag, "_px1"}, pq[base + 1], {24'h405060, 1'b0, 1'b1});
        check({tag, "_px2"}, pq[base + 2], {24'h708090, 1'b0, 1'b0});
        check({tag, "_px3"}, pq[base + 3], {24'hA0B0C0, 1'b0, 1'b1});
    endtask

    initial begin
        int base;
        int vsnap;
        int errs;
        logic [25:0] expv;
        logic [3:0]  bp;

        rst = 1'b1;
        start = 1'b0;
        pix_ready = 1'b1;
        load(16'd2, 16'd2, 8'h4D, 0, 12);
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        check("reset_addr_dims", {rom_addr, xdim, ydim}, 52'd0);
        check("reset_outputs", {pix_valid, r, g, b, sof, eol, busy, done, error}, 30'd0);
        step();
        rst = 1'b0;

        // 2x2 free-running
        base = pq.size();
        pulse_start();
        wait_done(100, "a_done");
        check_2x2(base, "a");
        check("a_dims", {xdim, ydim}, {16'd2, 16'd2});
        check("a_gap", tq[base + 1] - tq[base], 64'd3);
        check("a_idle_out", {pix_valid, busy, error}, 3'b000);

        // bad magic
        load(16'd2, 16'd2, 8'h49, 0, 12);
        vsnap = valid_cnt;
        pulse_start();
        wait_error(6, "magic_err");
        repeat (5) @(negedge pclk);
        check("magic_novalid", valid_cnt - vsnap, 0);
        check("magic_status", {busy, done, error, pix_valid}, 4'b0010);

        // xdim = 0
        load(16'd0, 16'd1, 8'h4D, 2, 0);
        vsnap = valid_cnt;
        pulse_start();
        wait_error(30, "xdim0_err");
        check("xdim0_novalid", valid_cnt - vsnap, 0);

        // xdim = MAX_DIM + 1
        load(16'd1025, 16'd1, 8'h4D, 2, 0);
        pulse_start();
        wait_error(30, "xdim1025_err");
        check("xdim1025_novalid", valid_cnt - vsnap, 0);

        // xdim = MAX_DIM, ydim = 1
        load(16'd1024, 16'd1, 8'h4D, 2, 3072);
        base = pq.size();
        pulse_start();
        wait_done(4000, "big_done");
        check("big_dims", {xdim, ydim}, {16'd1024, 16'd1});
        check("big_count", pq.size(), base + 1024);
        errs = 0;
        for (int k = 0; k < 1024; k++) begin
            expv = {pat(2, 3 * k), pat(2, 3 * k + 1), pat(2, 3 * k + 2), k == 0, k == 1023};
            if (pq[base + k] !== expv) errs++;
        end
        check("big_pix_errs", errs, 0);

        // 3x1 with backpressure 1,0,0,1
        load(16'd3, 16'd1, 8'h4D, 1, 9);
        base = pq.size();
        bp = 4'b1001;
        pulse_start();
        for (int k = 0; k < 300 && !done; k++) begin
            pix_ready = bp[k % 4];
            step();
        end
        pix_ready = 1'b1;
        check("bp_done", done, 1'b1);
        check("bp_count", pq.size(), base + 3);
        check("bp_px0", pq[base],     {24'h112233, 1'b1, 1'b0});
        check("bp_px1", pq[base + 1], {24'h445566, 1'b0, 1'b0});
        check("bp_px2", pq[base + 2], {24'h778899, 1'b0, 1'b1});

        // reset after the second pixel
        load(16'd2, 16'd2, 8'h4D, 0, 12);
        base = pq.size();
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            @(negedge pclk);
            if (pq.size() >= base + 2) break;
        end
        check("mid_two_px", pq.size(), base + 2);
        step();
        rst = 1'b1;
        @(posedge pclk);
        #1;
        rst = 1'b0;
        @(negedge pclk);
        check("mid_rst_addr_dims", {rom_addr, xdim, ydim}, 52'd0);
        check("mid_rst_outputs", {pix_valid, r, g, b, sof, eol, busy, done, error}, 30'd0);
        base = pq.size();
        pulse_start();
        wait_done(100, "mid_done");
        check_2x2(base, "mid");

        // start during STREAM is ignored, start in DONE restarts
        base = pq.size();
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            @(negedge pclk);
            if (pq.size() >= base + 1) break;
        end
        pulse_start();
        wait_done(100, "ign_done");
        check_2x2(base, "ign");
        base = pq.size();
        pulse_start();
        @(negedge pclk);
        check("restart_busy", {busy, done}, 2'b10);
        wait_done(100, "restart_done");
        check_2x2(base, "restart");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/image_stream_reader.md
IMAGE_STREAM_READER -- requirements
Module: image_stream_reader

Interface
REQ-001 Parameter ADDR_W, default 20, byte-address width of the image ROM.
REQ-002 Parameter MAX_DIM, default 1024, largest legal width or height in pixels.
REQ-003 pclk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse; begins decoding one image; ignored unless state is IDLE, DONE or ERR.
REQ-006 rom_addr  out  ADDR_W  byte address to a synchronous ROM.
REQ-007 rom_data  in  8  ROM byte; valid exactly 1 cycle after rom_addr is presented.
REQ-008 xdim, ydim  out  16 each  decoded width and height; held until the next start.
REQ-009 pix_valid  out  1  r/g/b hold a pixel.
REQ-010 pix_ready  in  1  consumer accepts the pixel on a cycle where pix_valid and pix_ready are both 1.
REQ-011 r, g, b  out  8 each  pixel colour.
REQ-012 sof  out  1  qualifies the first pixel of the frame.
REQ-013 eol  out  1  qualifies the last pixel of each row.
REQ-014 busy, done, error  out  1 each  status levels.

Function
REQ-015 Input format: big-endian, uncompressed 24-bit RGB. Bytes 0x00-0x03 = 4D 4D 00 2A. Width is the 16-bit field at 0x1C-0x1D. Height is the 16-bit field at 0x28-0x29. Pixel data starts at 0xC0 in R,G,B byte order, row-major, top row first.
REQ-016 The FSM states SHALL be IDLE, MAGIC, DIMS, CHECK, STREAM, DONE and ERR.
REQ-017 On an accepted start: enter MAGIC and fetch 0x00-0x03 at one address per cycle.
REQ-018 Any mismatch of the magic bytes SHALL go to ERR.
REQ-019 DIMS SHALL fetch 0x1C, 0x1D, 0x28 and 0x29 into xdim and ydim.
REQ-020 CHECK (1 cycle) SHALL go to ERR if xdim or ydim is 0 or exceeds MAX_DIM; otherwise it goes to STREAM with the address set to 0xC0.
REQ-021 STREAM SHALL issue one ROM read per cycle while the pixel pipeline has room. The packer SHALL assemble 3 consecutive bytes into one pixel.
REQ-022 Peak throughput SHALL be one pixel per 3 cycles.
REQ-023 Latency: the first pix_valid SHALL assert no later than 4 cycles after entering STREAM.
REQ-024 Backpressure: while pix_valid=1 and pix_ready=0, r, g, b, sof and eol SHALL stay stable. At most one further pixel may be buffered, and no byte may be lost or duplicated.
REQ-025 A column counter (0..xdim-1) and a row counter (0..ydim-1) SHALL advance on each handshake. eol is asserted at column xdim-1, and sof at row 0, column 0.
REQ-026 The handshake of pixel (xdim-1, ydim-1) SHALL move the FSM to DONE.
REQ-027 In DONE, pix_valid=0 and done=1 until the next start.
REQ-028 In ERR, error=1 and pix_valid=0 until the next start or rst.
REQ-029 busy SHALL be 1 in MAGIC, DIMS, CHECK and STREAM.
REQ-030 start while busy SHALL have no effect.
REQ-031 rom_addr arithmetic SHALL be unsigned ADDR_W bits. Image size 0xC0 + 3*xdim*ydim beyond 2^ADDR_W is the integrator's responsibility; the address wraps silently.

Reset
REQ-032 rst SHALL force IDLE in the cycle after it is sampled, including mid-STREAM. No handshake completes in that cycle.
REQ-033 Reset values: rom_addr=0, xdim=0, ydim=0, pix_valid=0, r=g=b=0, sof=0, eol=0, busy=0, done=0, error=0. Counters and the packer are cleared.

Structure
REQ-034 Package image_reader_pkg SHALL hold the FSM state enum, the magic constant 32'h4D4D002A and the offsets 0x1C, 0x28 and 0xC0.
REQ-035 Byte-to-pixel packing plus the one-entry skid buffer SHALL live in the sub-module rgb_packer (byte in with valid, valid/ready pixel out, room flag back to the fetch logic).

Verification
REQ-036 Back-to-back stream: 2x2 image, data 10 20 30 / 40 50 60 / 70 80 90 / A0 B0 C0, pix_ready=1 throughout -> 4 pixels in order. sof on 102030; eol on 405060 and A0B0C0; done=1; xdim=ydim=2.
REQ-037 Bad magic: byte 0x00=0x49 -> error=1 within 6 cycles of start; pix_valid never asserts.
REQ-038 Illegal dimensions: xdim=0 -> ERR. xdim=MAX_DIM+1 -> ERR. xdim=MAX_DIM, ydim=1 -> streams 1024 pixels.
REQ-039 Backpressure: 3x1 image with pix_ready toggling 1,0,0,1 repeatedly -> same 3 pixels as free-running, each held stable while stalled.
REQ-040 Reset mid-frame: rst pulsed after the 2nd pixel of 2x2 -> all outputs at reset values next cycle. A fresh start then yields all 4 pixels from the first.
REQ-041 start asserted during STREAM -> ignored; frame completes normally; a start in DONE restarts the decode.
